ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter that sends one command byte to the mouse, such as 0xF4 enable-reporting, 0xFF reset, or 0xF3 set-sample-rate. It runs the inhibit/request-to-send sequence, shifts out data, parity and stop bits on device-generated clock edges, and checks the device's line-ack bit. It sits beside the PS/2 mouse receiver in the 100 MHz domain and drives the open-drain ps2_clk/ps2_data pads through output enables. While busy is high, the receiver ignores incoming frames.

Parameters:
CLK_FREQ_HZ, 100_000_000, system clock frequency.
INHIBIT_US, 100, duration ps2_clk is held low before request-to-send.
FIRST_EDGE_TIMEOUT_US, 15000, maximum wait from clock release to the first device falling edge.
BIT_TIMEOUT_US, 1000, maximum gap between consecutive device falling edges.
FILTER_CYCLES, 8, number of consecutive equal samples needed to accept a ps2_clk level.

Ports:
clk  in  1  system clock, 100 MHz.
rst_n  in  1  asynchronous, active-low reset.
tx_data  in  8  command byte.
tx_valid  in  1  request to send tx_data.
tx_ready  out  1  block is idle and accepts a byte.
tx_done  out  1  one-cycle pulse: frame sent and line-ack received.
tx_err  out  1  one-cycle pulse: timeout or missing ack.
busy  out  1  high from byte acceptance until the block returns to IDLE.
ps2_clk_in  in  1  raw pad level of ps2_clk.
ps2_data_in  in  1  raw pad level of ps2_data.
ps2_clk_oe  out  1  1 = pull ps2_clk low; 0 = release.
ps2_data_oe  out  1  1 = pull ps2_data low; 0 = release.

Behaviour:
- Reset values: state IDLE; tx_ready=1; tx_done=0; tx_err=0; busy=0; both OEs=0; shift register and counters all 0.
- Input conditioning:
  - ps2_clk_in and ps2_data_in pass through a 2-FF synchronizer.
  - The clock level is accepted only after FILTER_CYCLES equal samples.
  - fall = one-cycle strobe on a filtered 1->0 transition.
- Accept: when tx_valid && tx_ready, latch {parity, tx_data}, where parity = ~^tx_data (odd parity). Go to INHIBIT on the next cycle. tx_ready is 1 only in IDLE.
- INHIBIT: clk_oe=1 for INHIBIT_US*CLK_FREQ_HZ/1e6 cycles, then go to RTS.
- RTS: data_oe=1 and clk_oe=1 for exactly 1 cycle. Then go to WAIT_FIRST with clk_oe=0 and data_oe=1; this is the start bit.
- WAIT_FIRST:
  - On fall: data_oe = ~d0, bit_cnt=1, go to SHIFT.
  - On timeout: go to ABORT.
- SHIFT:
  - Each fall drives the next bit: d1..d7, then parity at bit_cnt=8, then stop at bit_cnt=9 (data_oe=0).
  - After the stop bit, go to ACK.
  - The gap timer restarts on every fall; on BIT_TIMEOUT, go to ABORT.
- ACK:
  - On the next fall, sample the synced data.
  - 0 -> go to WAIT_IDLE.
  - 1 -> go to ABORT.
  - Gap timeout -> ABORT.
- WAIT_IDLE: when filtered clk=1 and data=1, pulse tx_done and go to IDLE. On BIT_TIMEOUT, go to ABORT.
- ABORT: both OEs=0; pulse tx_err for one cycle; go to IDLE.
- Exactly one of tx_done/tx_err pulses per accepted byte.
- busy = (state != IDLE).
- The OEs are registered, never combinational from the pads.
- tx_valid outside IDLE is ignored, with no queueing.
- Asynchronous reset mid-frame immediately releases both lines (OEs=0). The device detects the aborted frame by timeout itself.
- Counter width is $clog2 of the largest cycle count, which is 1_500_000 at the defaults (21 bits).

Decomposition:
- Shared package ps2_pkg holds:
  - the state enum (IDLE, INHIBIT, RTS, WAIT_FIRST, SHIFT, ACK, WAIT_IDLE, ABORT);
  - command constants PS2_CMD_RESET=8'hFF, PS2_CMD_ENABLE=8'hF4, PS2_CMD_SET_RATE=8'hF3;
  - the device response PS2_RSP_ACK=8'hFA;
  - the microsecond-to-cycles conversion function.
- One sub-module, ps2_line_sync: synchronizer, glitch filter and fall strobe. The receiver reuses it.

Test Plan:
- Send 0xF4 with CLK_FREQ_HZ=1_000_000 and INHIBIT_US=100 -> clk_oe is high for 100 cycles, the bit-level device model captures 0,0,1,0,1,1,1,1 then parity 0 and stop 1; model acks with data low -> one tx_done, busy back to 0.
- Send 0xFF -> the device model captures parity=1; tx_done pulses.
- Device model never clocks after RTS -> tx_err exactly FIRST_EDGE_TIMEOUT cycles after clock release; OEs=0; tx_ready=1.
- Device model leaves data high on the ack edge -> tx_err, no tx_done.
- Device model stops clocking after bit 4 -> tx_err after BIT_TIMEOUT; lines released.
- Assert rst_n low during SHIFT -> both OEs=0 in the same cycle with no clock edge; after release, tx_ready=1 and a new 0xF3 send completes normally.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter state encoding, mouse command bytes
// and the microsecond-to-cycle conversion used to size timers.
package ps2_pkg;

  typedef logic [2:0] ps2_state_t;

  localparam ps2_state_t ST_IDLE       = 3'd0;
  localparam ps2_state_t ST_INHIBIT    = 3'd1;
  localparam ps2_state_t ST_RTS        = 3'd2;
  localparam ps2_state_t ST_WAIT_FIRST = 3'd3;
  localparam ps2_state_t ST_SHIFT      = 3'd4;
  localparam ps2_state_t ST_ACK        = 3'd5;
  localparam ps2_state_t ST_WAIT_IDLE  = 3'd6;
  localparam ps2_state_t ST_ABORT      = 3'd7;

  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_SET_RATE = 8'hF3;
  localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;

  // 64-bit product: 100 MHz * 15000 us overflows 32 bits before the divide.
  function automatic int unsigned us_to_cycles(input int unsigned clk_hz, input int unsigned us);
    logic [63:0] prod;
    prod = (64'(clk_hz) * 64'(us)) / 64'd1_000_000;
    return prod[31:0];
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// PS/2 pad conditioning: 2-FF synchronizers on clock and data, a run-length
// glitch filter on the clock, and a one-cycle strobe on filtered falling edges.
module ps2_line_sync #(
  parameter int unsigned FILTER_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_pad_i,
  input  logic data_pad_i,
  output logic clk_filt_o,
  output logic data_sync_o,
  output logic fall_o
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);

  logic [1:0]    clk_sync_q;
  logic [1:0]    data_sync_q;
  logic          clk_filt_q, clk_filt_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The filtered level flips only after FILTER_CYCLES consecutive differing samples.
  always_comb begin
    clk_filt_d = clk_filt_q;
    cnt_d      = '0;
    fall_d     = 1'b0;
    if (clk_sync_q[1] != clk_filt_q) begin
      if (cnt_q == CW'(FILTER_CYCLES - 1)) begin
        clk_filt_d = clk_sync_q[1];
        fall_d     = clk_filt_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_filt_q  <= 1'b1;
      fall_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], clk_pad_i};
      data_sync_q <= {data_sync_q[0], data_pad_i};
      clk_filt_q  <= clk_filt_d;
      fall_q      <= fall_d;
      cnt_q       <= cnt_d;
    end
  end

  assign clk_filt_o  = clk_filt_q;
  assign data_sync_o = data_sync_q[1];
  assign fall_o      = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, bit shifting
// on device clock falls, line-ack check, with timeouts ending in a tx_err pulse.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ           = 100_000_000,
  parameter int unsigned INHIBIT_US            = 100,
  parameter int unsigned FIRST_EDGE_TIMEOUT_US = 15000,
  parameter int unsigned BIT_TIMEOUT_US        = 1000,
  parameter int unsigned FILTER_CYCLES         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned INHIBIT_CYC = us_to_cycles(CLK_FREQ_HZ, INHIBIT_US);
  localparam int unsigned FIRST_CYC   = us_to_cycles(CLK_FREQ_HZ, FIRST_EDGE_TIMEOUT_US);
  localparam int unsigned BIT_CYC     = us_to_cycles(CLK_FREQ_HZ, BIT_TIMEOUT_US);
  localparam int unsigned MAX_AB      = (INHIBIT_CYC > FIRST_CYC) ? INHIBIT_CYC : FIRST_CYC;
  localparam int unsigned MAX_CYC     = (MAX_AB > BIT_CYC) ? MAX_AB : BIT_CYC;
  localparam int          CNT_W       = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYC - 1);
  localparam logic [CNT_W-1:0] FIRST_LAST   = CNT_W'(FIRST_CYC - 1);
  localparam logic [CNT_W-1:0] BIT_LAST     = CNT_W'(BIT_CYC - 1);

  logic clk_filt, data_sync, fall;

  ps2_line_sync #(
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_line_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_pad_i  (ps2_clk_in),
    .data_pad_i (ps2_data_in),
    .clk_filt_o (clk_filt),
    .data_sync_o(data_sync),
    .fall_o     (fall)
  );

  ps2_state_t       state_q, state_d;
  logic [8:0]       shreg_q, shreg_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    cnt_d     = cnt_q + 1'b1;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d     = '0;
        bit_cnt_d = '0;
        if (tx_valid) begin
          shreg_d  = {~^tx_data, tx_data};
          clk_oe_d = 1'b1;
          state_d  = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (cnt_q == INHIBIT_LAST) begin
          data_oe_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_RTS;
        end
      end
      ST_RTS: begin
        clk_oe_d = 1'b0;
        cnt_d    = '0;
        state_d  = ST_WAIT_FIRST;
      end
      // Shifting in ones from the top makes the tenth fall present the stop bit.
      ST_WAIT_FIRST, ST_SHIFT: begin
        if (fall) begin
          data_oe_d = ~shreg_q[0];
          shreg_d   = {1'b1, shreg_q[8:1]};
          cnt_d     = '0;
          if (state_q == ST_WAIT_FIRST) begin
            bit_cnt_d = 4'd1;
            state_d   = ST_SHIFT;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == 4'd9) state_d = ST_ACK;
          end
        end else if (cnt_q == ((state_q == ST_WAIT_FIRST) ? FIRST_LAST : BIT_LAST)) begin
          state_d = ST_ABORT;
        end
      end
      ST_ACK: begin
        if (fall) begin
          cnt_d   = '0;
          state_d = data_sync ? ST_ABORT : ST_WAIT_IDLE;
        end else if (cnt_q == BIT_LAST) begin
          state_d = ST_ABORT;
        end
      end
      ST_WAIT_IDLE: begin
        if (clk_filt && data_sync) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q == BIT_LAST) begin
          state_d = ST_ABORT;
        end
      end
      ST_ABORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (state_d == ST_ABORT) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      err_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      cnt_q     <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      cnt_q     <= cnt_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign tx_ready    = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign tx_done     = done_q;
  assign tx_err      = err_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model and an
// expected-outcome queue checked when each frame finishes.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH_CYC   = 100;
  localparam int FIRST_CYC = 15000;
  localparam int BIT_CYC   = 1000;
  localparam int HALF      = 30;
  localparam int OUT_DONE  = 0;
  localparam int OUT_ERR   = 1;
  localparam int OUT_NONE  = 2;

  typedef struct {
    logic [7:0] data;
    logic       parity;
    int         outcome;
    bit         has_cap;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_err, busy, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_in, ps2_data_in;

  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .CLK_FREQ_HZ(1_000_000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_err     (tx_err),
    .busy       (busy),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  int   passed = 0;
  int   total = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;
  exp_t sb[$];

  always @(negedge clk) begin
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_err)  err_cnt  <= err_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input int outcome, input bit has_cap);
    exp_t e;
    e.data    = b;
    e.parity  = (($countones(b) % 2) == 0);
    e.outcome = outcome;
    e.has_cap = has_cap;
    sb.push_back(e);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Counts inhibit cycles, then checks the RTS cycle and the start-bit release.
  task automatic preamble(output int n);
    n = 0;
    while (ps2_clk_oe && !ps2_data_oe && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check("rts_clk_oe", 32'(ps2_clk_oe), 32'd1);
    check("rts_data_oe", 32'(ps2_data_oe), 32'd1);
    @(negedge clk);
    check("release_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("start_data_oe", 32'(ps2_data_oe), 32'd1);
  endtask

  // Device clocks nfalls bits, sampling data on each rising edge.
  task automatic dev_run(input int nfalls, input bit do_ack, input bit ack_low,
                         output logic [10:0] cap);
    cap = '0;
    wait_cycles(40);
    cap[0] = ps2_data_in;
    for (int k = 1; k <= nfalls; k++) begin
      dev_clk = 1'b0;
      wait_cycles(HALF);
      dev_clk = 1'b1;
      cap[k] = ps2_data_in;
      wait_cycles(HALF);
    end
    if (do_ack) begin
      dev_data = ack_low ? 1'b0 : 1'b1;
      dev_clk  = 1'b0;
      wait_cycles(HALF);
      dev_clk  = 1'b1;
      dev_data = 1'b1;
    end
  endtask

  task automatic wait_outcome(input int base);
    int n = 0;
    while ((done_cnt + err_cnt) == base && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("outcome_seen", 32'((done_cnt + err_cnt) != base), 32'd1);
    wait_cycles(3);
  endtask

  task automatic score(input logic [10:0] cap, input int d0, input int e0);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_nonempty", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    if (e.has_cap) begin
      check("start_bit", 32'(cap[0]), 32'd0);
      check("data_bits", 32'(cap[8:1]), 32'(e.data));
      check("parity_bit", 32'(cap[9]), 32'(e.parity));
      check("stop_bit", 32'(cap[10]), 32'd1);
    end
    check("done_pulses", 32'(done_cnt - d0), 32'(e.outcome == OUT_DONE));
    check("err_pulses", 32'(err_cnt - e0), 32'(e.outcome == OUT_ERR));
    $display("txn byte=%02h outcome=%0d frame=%011b done=%0d err=%0d",
             e.data, e.outcome, cap, done_cnt - d0, err_cnt - e0);
  endtask

  initial begin
    int n, d0, e0;
    logic [10:0] cap;

    rst_n = 1'b0;
    wait_cycles(3);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_done", 32'(tx_done), 32'd0);
    check("rst_tx_err", 32'(tx_err), 32'd0);
    check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
    rst_n = 1'b1;
    wait_cycles(20);

    // Enable reporting, acked normally
    d0 = done_cnt; e0 = err_cnt;
    send(PS2_CMD_ENABLE, OUT_DONE, 1'b1);
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_ready", 32'(tx_ready), 32'd0);
    preamble(n);
    check("inhibit_cycles", 32'(n), 32'(INH_CYC));
    dev_run(10, 1'b1, 1'b1, cap);
    wait_outcome(d0 + e0);
    score(cap, d0, e0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_ready", 32'(tx_ready), 32'd1);
    wait_cycles(50);

    // Reset command: parity bit is 1
    d0 = done_cnt; e0 = err_cnt;
    send(PS2_CMD_RESET, OUT_DONE, 1'b1);
    preamble(n);
    dev_run(10, 1'b1, 1'b1, cap);
    wait_outcome(d0 + e0);
    score(cap, d0, e0);
    wait_cycles(50);

    // Device never clocks: first-edge timeout measured from clock release
    d0 = done_cnt; e0 = err_cnt;
    send(PS2_CMD_ENABLE, OUT_ERR, 1'b0);
    preamble(n);
    n = 0;
    while (!tx_err && n < FIRST_CYC + 100) begin
      @(negedge clk);
      n++;
    end
    check("first_edge_timeout", 32'(n), 32'(FIRST_CYC));
    check("abort_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("abort_data_oe", 32'(ps2_data_oe), 32'd0);
    @(negedge clk);
    check("abort_ready", 32'(tx_ready), 32'd1);
    wait_outcome(d0 + e0);
    score(cap, d0, e0);
    wait_cycles(50);

    // Device leaves data high on the ack clock
    d0 = done_cnt; e0 = err_cnt;
    send(PS2_CMD_SET_RATE, OUT_ERR, 1'b1);
    preamble(n);
    dev_run(10, 1'b1, 1'b0, cap);
    wait_outcome(d0 + e0);
    score(cap, d0, e0);
    wait_cycles(50);

    // Device stops clocking mid-frame; a request while busy is ignored
    d0 = done_cnt; e0 = err_cnt;
    send(PS2_CMD_ENABLE, OUT_ERR, 1'b0);
    preamble(n);
    dev_run(5, 1'b0, 1'b0, cap);
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    wait_cycles(5);
    tx_valid = 1'b0;
    n = 2 * HALF + 5;
    while (!tx_err && n < BIT_CYC + 200) begin
      @(negedge clk);
      n++;
    end
    check("bit_timeout_window", 32'(n >= BIT_CYC && n <= BIT_CYC + 25), 32'd1);
    check("bit_to_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("bit_to_data_oe", 32'(ps2_data_oe), 32'd0);
    wait_outcome(d0 + e0);
    score(cap, d0, e0);
    wait_cycles(5);
    check("ignored_req_ready", 32'(tx_ready), 32'd1);
    check("ignored_req_busy", 32'(busy), 32'd0);
    wait_cycles(50);

    // Asynchronous reset while shifting releases both lines without a clock edge
    d0 = done_cnt; e0 = err_cnt;
    send(8'h00, OUT_NONE, 1'b0);
    preamble(n);
    dev_run(4, 1'b0, 1'b0, cap);
    check("shift_busy", 32'(busy), 32'd1);
    check("shift_data_oe", 32'(ps2_data_oe), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("async_data_oe", 32'(ps2_data_oe), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cycles(20);
    check("post_rst_ready", 32'(tx_ready), 32'd1);
    score(cap, d0, e0);

    // Normal frame after reset
    d0 = done_cnt; e0 = err_cnt;
    send(PS2_CMD_SET_RATE, OUT_DONE, 1'b1);
    preamble(n);
    check("inhibit_cycles_2", 32'(n), 32'(INH_CYC));
    dev_run(10, 1'b1, 1'b1, cap);
    wait_outcome(d0 + e0);
    score(cap, d0, e0);
    check("final_busy", 32'(busy), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
